// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int PERF_W     = 32;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  // One Avalon-MM request at the default geometry.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   address;
    logic [DEF_DATA_W/8-1:0] byteenable;
    logic                    read;
    logic                    write;
    logic [DEF_DATA_W-1:0]   writedata;
  } mem_req_t;

  // Saturating event counter step.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                input logic              en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin, or fixed priority to requester 0.
// The grant is combinational; last_grant remembers the most recent winner
// and resets to requester 1 so requester 0 wins the first conflict.
module rr_arbiter2
  import onchip_mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  master_id_e last_grant;
  logic       prefer0;

  // Pick the winner for this cycle.
  always_comb begin
    prefer0 = FIXED_PRIO || (last_grant == M1);
    gnt0    = req0 & (~req1 | prefer0);
    gnt1    = req1 & ~gnt0;
  end

  // Only a cycle with an actual grant moves the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
    end else if (gnt0) begin
      last_grant <= M0;
    end else if (gnt1) begin
      last_grant <= M1;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM (registered address, 1-cycle read latency)
// between two Avalon-MM masters, one access per cycle.
// Optional performance counters are built when ONCHIP_MEM_ARB_PERF_EN is defined.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int M0_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef ONCHIP_MEM_ARB_PERF_EN
  ,
  input  logic                perf_clear,
  output logic [PERF_W-1:0]   perf_m0_grants,
  output logic [PERF_W-1:0]   perf_m1_grants,
  output logic [PERF_W-1:0]   perf_conflicts
`endif
);

  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } req_t;

  req_t              r0, r1, sel, held_q;
  logic              req0, req1, gnt0, gnt1, granted;
  logic              rd_pend;
  master_id_e        rd_owner;
  logic [DATA_W-1:0] rd_hold0, rd_hold1;

  // Pack each master's request; read with write also high is a plain write.
  always_comb begin
    r0.address    = m0_address;
    r0.byteenable = m0_byteenable;
    r0.read       = m0_read & ~m0_write;
    r0.write      = m0_write;
    r0.writedata  = m0_writedata;
    r1.address    = m1_address;
    r1.byteenable = m1_byteenable;
    r1.read       = m1_read & ~m1_write;
    r1.write      = m1_write;
    r1.writedata  = m1_writedata;
  end

  // Nothing is granted while reset is high.
  assign req0 = ~reset & (m0_read | m0_write);
  assign req1 = ~reset & (m1_read | m1_write);

  rr_arbiter2 #(
    .FIXED_PRIO (M0_PRIORITY != 0)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign granted = gnt0 | gnt1;

  // Route the winner to the RAM; idle cycles re-present the last request.
  always_comb begin
    sel = held_q;
    if (gnt0) begin
      sel = r0;
    end else if (gnt1) begin
      sel = r1;
    end
  end

  // Remember the last granted request so the RAM address holds when idle.
  always_ff @(posedge clk) begin
    if (granted) begin
      held_q <= sel;
    end
  end

  assign mem_address    = sel.address;
  assign mem_byteenable = sel.byteenable;
  assign mem_writedata  = sel.writedata;
  assign mem_chipselect = granted;
  assign mem_write      = granted & sel.write;
  assign mem_clken      = ~reset;

  // Only a requester that lost arbitration stalls; idle masters never do.
  assign m0_waitrequest = reset | ((m0_read | m0_write) & ~gnt0);
  assign m1_waitrequest = reset | ((m1_read | m1_write) & ~gnt1);

  // Track the single read in flight so its data returns to its issuer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= M0;
    end else begin
      rd_pend <= granted & sel.read;
      if (granted) begin
        rd_owner <= gnt1 ? M1 : M0;
      end
    end
  end

  // A read caught by reset is dropped, even in the return cycle itself.
  assign m0_readdatavalid = ~reset & rd_pend & (rd_owner == M0);
  assign m1_readdatavalid = ~reset & rd_pend & (rd_owner == M1);

  // Keep each master's last returned word so non-owners see stable data.
  always_ff @(posedge clk) begin
    if (m0_readdatavalid) begin
      rd_hold0 <= mem_readdata;
    end
    if (m1_readdatavalid) begin
      rd_hold1 <= mem_readdata;
    end
  end

  assign m0_readdata = m0_readdatavalid ? mem_readdata : rd_hold0;
  assign m1_readdata = m1_readdatavalid ? mem_readdata : rd_hold1;

`ifdef ONCHIP_MEM_ARB_PERF_EN
  // Saturating grant/conflict counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_m0_grants <= '0;
      perf_m1_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_m0_grants <= sat_inc(perf_m0_grants, gnt0);
      perf_m1_grants <= sat_inc(perf_m1_grants, gnt1);
      perf_conflicts <= sat_inc(perf_conflicts, req0 & req1);
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a round-robin instance backed by a RAM model
// and a fixed-priority instance sharing the same stimulus. A per-cycle
// reference model checks both; literal checks pin the directed scenarios.
// Counter checks are included when ONCHIP_MEM_ARB_PERF_EN is defined.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic [7:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;

  logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_m0_readdatavalid, fp_m1_readdatavalid;
  logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_mem_writedata;
  logic [7:0]  fp_mem_address;
  logic [3:0]  fp_mem_byteenable;
  logic        fp_mem_chipselect, fp_mem_write, fp_mem_clken;

`ifdef ONCHIP_MEM_ARB_PERF_EN
  logic        perf_clear = 1'b0;
  logic [31:0] perf_m0_grants, perf_m1_grants, perf_conflicts;
  logic [31:0] fp_perf_m0_grants, fp_perf_m1_grants, fp_perf_conflicts;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .M0_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef ONCHIP_MEM_ARB_PERF_EN
    , .perf_clear(perf_clear), .perf_m0_grants(perf_m0_grants),
    .perf_m1_grants(perf_m1_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  onchip_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .M0_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fp_m0_waitrequest),
    .m0_readdata(fp_m0_readdata), .m0_readdatavalid(fp_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fp_m1_waitrequest),
    .m1_readdata(fp_m1_readdata), .m1_readdatavalid(fp_m1_readdatavalid),
    .mem_address(fp_mem_address), .mem_byteenable(fp_mem_byteenable),
    .mem_chipselect(fp_mem_chipselect), .mem_write(fp_mem_write),
    .mem_writedata(fp_mem_writedata), .mem_clken(fp_mem_clken), .mem_readdata(32'h0)
`ifdef ONCHIP_MEM_ARB_PERF_EN
    , .perf_clear(perf_clear), .perf_m0_grants(fp_perf_m0_grants),
    .perf_m1_grants(fp_perf_m1_grants), .perf_conflicts(fp_perf_conflicts)
`endif
  );

  // RAM: registered address, byte-enabled write, unregistered q.
  logic [31:0] ram [256];
  logic [7:0]  ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant rule, memory contents, one-deep read return.
  logic [31:0] ref_mem [256];
  int          last_w = 1;
  bit          pend = 0, fp_pend = 0, have_addr = 0;
  int          pend_own = 0, fp_own = 0;
  logic [31:0] pend_data = '0;
  logic [7:0]  last_addr = '0;
  bit          have_rd [2];
  logic [31:0] hold [2];

  always @(negedge clk) begin
    bit q0, q1, wr, fp_wr;
    int win, fpwin;
    logic [7:0] a;
    logic [3:0] be;
    logic [31:0] d;
    if (reset) begin
      chk("m_rst_m0_wait", m0_waitrequest, 1);
      chk("m_rst_m1_wait", m1_waitrequest, 1);
      chk("m_rst_cs", mem_chipselect, 0);
      chk("m_rst_we", mem_write, 0);
      chk("m_rst_m0_rdv", m0_readdatavalid, 0);
      chk("m_rst_m1_rdv", m1_readdatavalid, 0);
      chk("m_rst_clken", mem_clken, 0);
      chk("m_rst_fp_waits", {fp_m0_waitrequest, fp_m1_waitrequest}, 2'b11);
      chk("m_rst_fp_cs", fp_mem_chipselect, 0);
      chk("m_rst_fp_rdv", {fp_m0_readdatavalid, fp_m1_readdatavalid}, 0);
      last_w = 1; pend = 0; fp_pend = 0;
      have_rd[0] = 0; have_rd[1] = 0;
    end else begin
      q0 = m0_read | m0_write;
      q1 = m1_read | m1_write;
      win = -1;
      if (q0 && q1) win = (last_w == 1) ? 0 : 1;
      else if (q0) win = 0;
      else if (q1) win = 1;
      fpwin = q0 ? 0 : (q1 ? 1 : -1);

      chk("m_m0_rdv", m0_readdatavalid, pend && pend_own == 0);
      chk("m_m1_rdv", m1_readdatavalid, pend && pend_own == 1);
      if (pend && pend_own == 0) chk("m_m0_rdata", m0_readdata, pend_data);
      else if (have_rd[0])       chk("m_m0_rdata_hold", m0_readdata, hold[0]);
      if (pend && pend_own == 1) chk("m_m1_rdata", m1_readdata, pend_data);
      else if (have_rd[1])       chk("m_m1_rdata_hold", m1_readdata, hold[1]);

      chk("m_m0_wait", m0_waitrequest, q0 && win != 0);
      chk("m_m1_wait", m1_waitrequest, q1 && win != 1);
      chk("m_cs", mem_chipselect, win >= 0);
      chk("m_clken", mem_clken, 1);
      wr = 0; a = '0; be = '0; d = '0;
      if (win >= 0) begin
        a  = (win == 0) ? m0_address : m1_address;
        be = (win == 0) ? m0_byteenable : m1_byteenable;
        d  = (win == 0) ? m0_writedata : m1_writedata;
        wr = (win == 0) ? m0_write : m1_write;
        chk("m_addr", mem_address, a);
        chk("m_be", mem_byteenable, be);
        chk("m_we", mem_write, wr);
        if (wr) chk("m_wdata", mem_writedata, d);
      end else begin
        chk("m_we_idle", mem_write, 0);
        if (have_addr) chk("m_addr_hold", mem_address, last_addr);
      end

      chk("m_fp_m0_wait", fp_m0_waitrequest, q0 && fpwin != 0);
      chk("m_fp_m1_wait", fp_m1_waitrequest, q1 && fpwin != 1);
      chk("m_fp_cs", fp_mem_chipselect, fpwin >= 0);
      chk("m_fp_m0_rdv", fp_m0_readdatavalid, fp_pend && fp_own == 0);
      chk("m_fp_m1_rdv", fp_m1_readdatavalid, fp_pend && fp_own == 1);
      fp_wr = (fpwin == 0) ? m0_write : m1_write;
      if (fpwin >= 0) chk("m_fp_addr", fp_mem_address, (fpwin == 0) ? m0_address : m1_address);

      if (pend) begin
        have_rd[pend_own] = 1;
        hold[pend_own] = pend_data;
      end
      pend = 0;
      if (win >= 0) begin
        last_w = win; last_addr = a; have_addr = 1;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
          pend = 1; pend_own = win; pend_data = ref_mem[a];
        end
      end
      fp_pend = (fpwin >= 0) && !fp_wr;
      fp_own = fpwin;
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0,
                       input logic [3:0] b0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1,
                       input logic [3:0] b1, input logic [31:0] d1);
    @(posedge clk); #1;
    reset = 1'b0;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = b0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = b1; m1_writedata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 8'h00, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("lit_reset_m0_wait", m0_waitrequest, 1);
    chk("lit_reset_cs", mem_chipselect, 0);
    idle();
    @(negedge clk);
    chk("lit_idle_m0_wait", m0_waitrequest, 0);
    chk("lit_idle_m1_wait", m1_waitrequest, 0);

    for (int i = 0; i < 8; i++)
      drive(0, 1, 8'(32'h20 + i), 4'hF, 32'hA000_0000 + i, 0, 0, 8'h00, 4'h0, 32'h0);

    drive(0, 1, 8'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, 8'h00, 4'h0, 32'h0);
    @(negedge clk);
    chk("lit_wr_we", mem_write, 1);
    chk("lit_wr_addr", mem_address, 32'h10);
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 8'h10, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_rd_m1_wait", m1_waitrequest, 0);
    idle();
    @(negedge clk);
    chk("lit_rd_m1_rdv", m1_readdatavalid, 1);
    chk("lit_rd_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
    chk("lit_rd_m0_rdv", m0_readdatavalid, 0);

    // Both masters read every cycle, losers hold their address.
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 8'(32'h20 + (k + 1) / 2), 4'hF, 32'h0,
            1, 0, 8'(32'h24 + k / 2), 4'hF, 32'h0);
      @(negedge clk);
      chk("lit_rr_m0_wait", m0_waitrequest, k % 2);
      chk("lit_rr_m1_wait", m1_waitrequest, 1 - k % 2);
      if (k % 2 == 1) begin
        chk("lit_rr_m0_rdv", m0_readdatavalid, 1);
        chk("lit_rr_m0_rdata", m0_readdata, 32'hA000_0000 + (k - 1) / 2);
      end else if (k > 0) begin
        chk("lit_rr_m1_rdv", m1_readdatavalid, 1);
        chk("lit_rr_m1_rdata", m1_readdata, 32'hA000_0004 + (k - 2) / 2);
      end
    end
    idle();
    @(negedge clk);
    chk("lit_rr_last_rdata", m1_readdata, 32'hA000_0007);

    drive(0, 1, 8'h05, 4'hF, 32'h1122_3344, 0, 0, 8'h00, 4'h0, 32'h0);
    drive(0, 1, 8'h05, 4'h2, 32'h0000_AB00, 0, 0, 8'h00, 4'h0, 32'h0);
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 8'h05, 4'hF, 32'h0);
    idle();
    @(negedge clk);
    chk("lit_byte_rdv", m1_readdatavalid, 1);
    chk("lit_byte_rdata", m1_readdata, 32'h1122_AB44);

    drive(1, 1, 8'h06, 4'hF, 32'h0000_0055, 0, 0, 8'h00, 4'h0, 32'h0);
    drive(1, 0, 8'h06, 4'hF, 32'h0, 0, 0, 8'h00, 4'h0, 32'h0);
    @(negedge clk);
    chk("lit_rw_no_rdv", m0_readdatavalid, 0);
    idle();
    @(negedge clk);
    chk("lit_rw_rdata", m0_readdata, 32'h0000_0055);

    // Reset lands in the return cycle of an m0 read.
    drive(1, 0, 8'h10, 4'hF, 32'h0, 0, 0, 8'h00, 4'h0, 32'h0);
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_drop_rdv", m0_readdatavalid, 0);
    chk("lit_rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    drive(1, 0, 8'h10, 4'hF, 32'h0, 1, 0, 8'h20, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_post_rst_m0_wait", m0_waitrequest, 0);
    chk("lit_post_rst_m1_wait", m1_waitrequest, 1);
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 8'h20, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_post_rst_m1_gnt", m1_waitrequest, 0);
    chk("lit_post_rst_rdata", m0_readdata, 32'hDEAD_BEEF);
    idle();

    // Fixed-priority instance under continuous contention.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 8'h21, 4'hF, 32'h0, 1, 0, 8'h22, 4'hF, 32'h0);
      @(negedge clk);
      chk("lit_fp_m0_wait", fp_m0_waitrequest, 0);
      chk("lit_fp_m1_wait", fp_m1_waitrequest, 1);
    end
    drive(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 8'h22, 4'hF, 32'h0);
    @(negedge clk);
    chk("lit_fp_m1_gnt", fp_m1_waitrequest, 0);
    idle();
    idle();

`ifdef ONCHIP_MEM_ARB_PERF_EN
    perf_clear = 1'b1;
    idle();
    perf_clear = 1'b0;
    for (int k = 0; k < 4; k++)
      drive(1, 0, 8'h21, 4'hF, 32'h0, 1, 0, 8'h22, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++)
      drive(0, 0, 8'h00, 4'h0, 32'h0, 1, 0, 8'h23, 4'hF, 32'h0);
    idle();
    @(negedge clk);
    chk("lit_perf_conflicts", perf_conflicts, 4);
    chk("lit_perf_m0", perf_m0_grants, 2);
    chk("lit_perf_m1", perf_m1_grants, 5);
    perf_clear = 1'b1;
    drive(1, 0, 8'h21, 4'hF, 32'h0, 1, 0, 8'h22, 4'hF, 32'h0);
    perf_clear = 1'b1;
    idle();
    perf_clear = 1'b0;
    @(negedge clk);
    chk("lit_perf_clr_conf", perf_conflicts, 0);
    chk("lit_perf_clr_m0", perf_m0_grants, 0);
    chk("lit_perf_clr_m1", perf_m1_grants, 0);
`endif

    idle();
    idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (256 x 32, byte-enabled, registered address, unregistered q, 1-cycle read latency) between two Avalon-MM requesters: CPU data master (m0) and DMA/video master (m1).
- Round-robin grant, at most one RAM access per cycle; pipelined reads returned with readdatavalid to the owning requester.
- Sits between the interconnect and the RAM instance inside the SoC subsystem.

Parameters:
- ADDR_W, 8, word address width (RAM depth = 2**ADDR_W)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- M0_PRIORITY, 0, 1 = m0 wins all conflicts (fixed priority); 0 = round-robin

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q (valid 1 cycle after read address)

Behaviour:
- Request valid: mX_read | mX_write. read & write both high = write only (read ignored, no readdatavalid).
- Grant combinational in same cycle: single requester → granted; both → M0_PRIORITY ? m0 : requester not granted last (last_grant register, reset to m1 so m0 wins first conflict).
- Granted master: waitrequest=0, its signals muxed to mem_*; mem_chipselect=1, mem_write=granted write. Loser: waitrequest=1, must hold request stable.
- Idle master: waitrequest=0 (no-request cycles never stall). No request: mem_chipselect=0, mem_write=0, mem_address holds last value.
- last_grant updates only on a cycle with an actual grant.
- Read pipeline: grant of a read sets rd_pend=1, rd_owner=X; next cycle mX_readdatavalid=1, mX_readdata=mem_readdata. Back-to-back reads from alternating masters every cycle: one readdatavalid per cycle, ordered.
- readdata to non-owner holds previous value; only readdatavalid qualifies.
- Write: single cycle, no response. Write-then-read same address next cycle returns new data.
- mem_clken = ~reset.
- Reset (any cycle, including mid-read): rd_pend=0, all readdatavalid=0 next cycle, last_grant=m1, mem_chipselect=0, mem_write=0; waitrequest=1 for both masters while reset high. In-flight read is dropped, not returned.
- Throughput: 1 access/cycle; worst-case wait under round-robin = 1 cycle per contended access.

Optional Feature:
- Macro ONCHIP_MEM_ARB_PERF_EN.
- Defined: adds outputs perf_m0_grants, perf_m1_grants, perf_conflicts (32-bit each), plus input perf_clear (synchronous clear). Counters increment per grant / per cycle both requested; saturate at 2**32-1; cleared by reset or perf_clear (clear wins over increment).
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package onchip_mem_arb_pkg: master ID enum (M0, M1), DATA_W/ADDR_W defaults, request struct {address, byteenable, read, write, writedata}.
- One sub-module natural: rr_arbiter2 (2-way round-robin/fixed-priority grant + last_grant register), reused by other shared-RAM blocks.

Test Plan:
- m0 write 0xDEADBEEF @0x10 be=0xF, then m1 read @0x10 → m1_readdatavalid 1 cycle after grant, m1_readdata=0xDEADBEEF, m0_readdatavalid stays 0.
- Both read every cycle for 8 cycles, RR → grants m0,m1,m0,...; each master waitrequest alternates; 8 readdatavalids, in order, correct data.
- M0_PRIORITY=1, both request continuously 5 cycles → m0 granted all 5, m1_waitrequest=1 throughout; m1 granted when m0 drops.
- Byte write be=0x2 data 0x0000AB00 over 0x11223344 @0x05, read back → 0x1122AB44.
- Reset asserted cycle after read grant → no readdatavalid, last_grant=m1, first post-reset conflict grants m0.
- (PERF_EN) 4 conflicts + 3 solo m1 grants → perf_conflicts=4, perf_m0_grants=2, perf_m1_grants=5; perf_clear → all 0 next cycle.
